data_memory_responder: RTL and testbench
========================================

# data_memory_responder

Multi-cycle data memory that services the load/store, cache-fill and dirty-line writeback requests issued by the processor controller's cache-miss state machine. It accepts one request at a time on a req/ack handshake and holds it for a fixed, parameterised latency. It then performs the write or returns read data with a one-cycle `ack`. It sits between the cache/controller datapath and the backing store, and is the responder end of the controller's memory-access protocol.

## Interface
- `ADDR_W`, 12: byte-address width; array holds 2^(ADDR_W-2) 32-bit words.
- `LATENCY`, 4: cycles from request acceptance to `ack`; legal range 1..15.
- `clk` in 1: single clock; all state changes on rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `req` in 1: request valid; sampled only in IDLE.
- `we` in 1: 1 = write, 0 = read.
- `is_word` in 1: 1 = 32-bit access, 0 = byte access.
- `addr` in ADDR_W: byte address.
- `wdata` in 32: write data; byte writes use `wdata[7:0]`.
- `busy` out 1: request in flight; new `req` is ignored while high.
- `ack` out 1: one-cycle completion pulse.
- `rdata` out 32: read data, valid while `ack` is high for reads.
- `proto_err` out 1: sticky protocol-error flag (see Configuration).

## Operation
- FSM states, held in a 2-bit register:
  - IDLE: a cycle with `req`=1 latches `we`, `is_word`, `addr`, `wdata`, loads counter = LATENCY-1, goes to WAIT. With LATENCY=1, goes directly to RESP.
  - WAIT: counter decrements each cycle; at 0, goes to RESP.
  - RESP: `ack`=1; writes commit to the array on this cycle's closing edge; next state is IDLE.
- Array addressing: word index = latched `addr[ADDR_W-1:2]`. Word accesses ignore `addr[1:0]`.
- Byte lane = `addr[1:0]`, little-endian (lane 0 = bits 7:0).
- Byte write: only the selected lane changes; other three bytes are preserved.
- Byte read: selected byte placed in `rdata[7:0]`, `rdata[31:8]`=0. Sign extension belongs to the consumer.
- Write `ack`: `rdata` holds its previous value.
- Read data reflects every write whose `ack` has already occurred. Read-after-write to the same address returns the new data.

## Timing
- Request sampled at edge N. `busy`=1 from cycle N+1 through the `ack` cycle inclusive. `ack`=1 in cycle N+LATENCY only.
- `busy`=0 on the cycle after `ack`.
- Back-to-back: `req` held high through `ack` is accepted on the first IDLE cycle. Minimum request spacing is LATENCY+1 cycles.
- `req` while `busy`=1 is dropped, never queued. The requester must hold `req` until it sees `busy` rise.
- Reset values: state=IDLE, counter=0, `busy`=0, `ack`=0, `rdata`=0, `proto_err`=0.
- Reset asserted mid-operation aborts the request. An uncommitted write is lost; array contents are untouched by reset.
- Array contents after power-up are undefined; benches initialise by writing.

## Configuration
- Macro `DATA_MEMORY_RESPONDER_PROTOCOL_CHECK_EN`.
- Defined: `proto_err` sets, and stays set until `rst_n` low, on either of:
  - `req`=1 while `busy`=1;
  - an accepted word access with `addr[1:0]`≠0.
  
  Functional behaviour is otherwise identical.
- Undefined: `proto_err` is tied to 0 and no check logic is built.

## Structure
- Package `data_memory_pkg`: state enum (IDLE, WAIT, RESP), `WORD_W`=32, `BYTE_LANES`=4, and a function that builds the byte-enable mask from `is_word` and `addr[1:0]`.
- Sub-module `data_memory_array`: synchronous-write, combinational-read word array with per-byte write enables. No reset.
- Top level contains the FSM, latency counter, request latches and read-lane extraction.

## Test plan
- LATENCY=4: word write 0xDEADBEEF @0x010 at edge 0 -> `ack` in cycle 4, `busy` high in cycles 1-4; word read @0x010 -> `rdata`=0xDEADBEEF with `ack`.
- Byte write 0xAA @0x013 over word 0x11223344 @0x010 -> word read returns 0xAA223344; byte read @0x012 -> 0x00000022.
- `req` pulsed in cycle 2 of an in-flight read -> no second `ack`; `proto_err`=1 with macro, 0 without.
- Reset asserted in WAIT of write 0x5 @0x020 (previously 0x0) -> `busy`/`ack`=0 immediately; later read @0x020 returns 0x0.
- LATENCY=1, `req` held high for 6 cycles -> `ack` in cycles 1, 3, 5; each read returns the addressed word.
- Word read @0x011 with macro -> returns word @0x010, `proto_err` sets and stays set until reset.

Source files
------------

// File: rtl/data_memory_pkg.sv
// Shared types and helpers for the data memory responder.
// Optional checker macro: DATA_MEMORY_RESPONDER_PROTOCOL_CHECK_EN (used by the top level).
package data_memory_pkg;

  localparam int unsigned WORD_W     = 32;
  localparam int unsigned BYTE_LANES = 4;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWait = 2'd1,
    StResp = 2'd2
  } state_e;

  // Word accesses touch every lane; byte accesses only the addressed lane.
  function automatic logic [BYTE_LANES-1:0] byte_mask(input logic       is_word,
                                                      input logic [1:0] lane);
    logic [BYTE_LANES-1:0] one;
    one = BYTE_LANES'(1);
    if (is_word) begin
      return '1;
    end
    return one << lane;
  endfunction

endpackage

// File: rtl/data_memory_array.sv
// Word array with synchronous per-byte writes and combinational reads; no reset.
module data_memory_array
  import data_memory_pkg::*;
#(
  parameter int unsigned IdxW = 10
) (
  input  logic                  clk_i,
  input  logic [IdxW-1:0]       waddr_i,
  input  logic [BYTE_LANES-1:0] wbe_i,
  input  logic [WORD_W-1:0]     wdata_i,
  input  logic [IdxW-1:0]       raddr_i,
  output logic [WORD_W-1:0]     rdata_o
);

  localparam int unsigned Depth = 1 << IdxW;

  logic [WORD_W-1:0] mem_q [Depth];

  always_ff @(posedge clk_i) begin
    for (int i = 0; i < BYTE_LANES; i++) begin
      if (wbe_i[i]) begin
        mem_q[waddr_i][i*8 +: 8] <= wdata_i[i*8 +: 8];
      end
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/data_memory_responder.sv
// Fixed-latency req/ack data memory responder for cache fills, writebacks and loads/stores.
// DATA_MEMORY_RESPONDER_PROTOCOL_CHECK_EN builds a sticky protocol-error checker.
module data_memory_responder
  import data_memory_pkg::*;
#(
  parameter int unsigned ADDR_W  = 12,
  parameter int unsigned LATENCY = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              we,
  input  logic              is_word,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              busy,
  output logic              ack,
  output logic [31:0]       rdata,
  output logic              proto_err
);

  localparam int unsigned IdxW    = ADDR_W - 2;
  localparam logic [3:0]  CntLoad = 4'(LATENCY - 1);

  state_e state_q, state_d;
  logic [3:0] cnt_q, cnt_d;

  logic              we_q;
  logic              is_word_q;
  logic [ADDR_W-1:0] addr_q;
  logic [WORD_W-1:0] wdata_q;
  logic [WORD_W-1:0] rdata_q, rdata_d;

  logic                  accept;
  logic [IdxW-1:0]       rd_idx;
  logic [1:0]            rd_lane;
  logic                  rd_is_word;
  logic                  rd_load;
  logic [WORD_W-1:0]     rd_word;
  logic [BYTE_LANES-1:0] wbe;
  logic [WORD_W-1:0]     arr_wdata;

  assign accept = (state_q == StIdle) && req;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (req) begin
          cnt_d   = CntLoad;
          state_d = (LATENCY == 1) ? StResp : StWait;
        end
      end
      StWait: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d = StResp;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q      <= 1'b0;
      is_word_q <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
    end else if (accept) begin
      we_q      <= we;
      is_word_q <= is_word;
      addr_q    <= addr;
      wdata_q   <= wdata;
    end
  end

  // Read data is registered on the edge into RESP; with LATENCY=1 that is the
  // accepting edge, so the live request fields stand in for the latches.
  always_comb begin
    rd_idx     = accept ? addr[ADDR_W-1:2] : addr_q[ADDR_W-1:2];
    rd_lane    = accept ? addr[1:0] : addr_q[1:0];
    rd_is_word = accept ? is_word : is_word_q;
    rd_load    = (state_d == StResp) && (accept ? !we : !we_q);
    rdata_d    = rdata_q;
    if (rd_load) begin
      rdata_d = rd_is_word ? rd_word : {24'd0, rd_word[{rd_lane, 3'b000} +: 8]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  // Writes commit only on the closing edge of RESP, so a reset before then drops them.
  always_comb begin
    wbe       = '0;
    arr_wdata = is_word_q ? wdata_q : {4{wdata_q[7:0]}};
    if ((state_q == StResp) && we_q) begin
      wbe = byte_mask(is_word_q, addr_q[1:0]);
    end
  end

  data_memory_array #(
    .IdxW(IdxW)
  ) u_array (
    .clk_i   (clk),
    .waddr_i (addr_q[ADDR_W-1:2]),
    .wbe_i   (wbe),
    .wdata_i (arr_wdata),
    .raddr_i (rd_idx),
    .rdata_o (rd_word)
  );

  assign busy  = (state_q != StIdle);
  assign ack   = (state_q == StResp);
  assign rdata = rdata_q;

`ifdef DATA_MEMORY_RESPONDER_PROTOCOL_CHECK_EN
  logic proto_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      proto_err_q <= 1'b0;
    end else if ((req && busy) || (accept && is_word && (addr[1:0] != 2'b00))) begin
      proto_err_q <= 1'b1;
    end
  end

  assign proto_err = proto_err_q;
`else
  assign proto_err = 1'b0;
`endif

endmodule

// File: tb/tb_data_memory_responder.sv
// Randomized self-checking bench for data_memory_responder (LATENCY=4 and LATENCY=1 instances).
module tb_data_memory_responder;

`ifdef DATA_MEMORY_RESPONDER_PROTOCOL_CHECK_EN
  localparam bit PcEn = 1'b1;
`else
  localparam bit PcEn = 1'b0;
`endif

  localparam int LatA = 4;
  localparam int LatB = 1;

  logic        clk;
  logic        rst_n;
  logic        req_a, req_b;
  logic        we, is_word;
  logic [11:0] addr;
  logic [31:0] wdata;
  logic        busy_a, ack_a, perr_a;
  logic        busy_b, ack_b, perr_b;
  logic [31:0] rdata_a, rdata_b;

  int vectors;
  int errors;

  logic [31:0] ref_a [1024];
  logic [31:0] ref_b [1024];

  data_memory_responder #(
    .ADDR_W (12),
    .LATENCY(LatA)
  ) u_dut_a (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req_a),
    .we       (we),
    .is_word  (is_word),
    .addr     (addr),
    .wdata    (wdata),
    .busy     (busy_a),
    .ack      (ack_a),
    .rdata    (rdata_a),
    .proto_err(perr_a)
  );

  data_memory_responder #(
    .ADDR_W (12),
    .LATENCY(LatB)
  ) u_dut_b (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req_b),
    .we       (we),
    .is_word  (is_word),
    .addr     (addr),
    .wdata    (wdata),
    .busy     (busy_b),
    .ack      (ack_b),
    .rdata    (rdata_b),
    .proto_err(perr_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1);
  end

  // Reference: what a read of (word, is_word, lane) should return.
  function automatic logic [31:0] exp_read(input logic [31:0] word, input logic iw, input int lane);
    if (iw) return word;
    return (word >> (8 * lane)) & 32'hFF;
  endfunction

  function automatic logic [31:0] exp_write(input logic [31:0] word, input logic iw, input int lane,
                                            input logic [31:0] d);
    logic [31:0] mask;
    if (iw) return d;
    mask = 32'hFF << (8 * lane);
    return (word & ~mask) | ((d & 32'hFF) << (8 * lane));
  endfunction

  // One transaction on instance A (sel=0) or B (sel=1); ends on the idle cycle after ack.
  task automatic access(input bit sel, input logic w, input logic iw, input logic [11:0] a,
                        input logic [31:0] d, output int lat, output logic [31:0] rd,
                        output bit busy_bad);
    logic b;
    @(negedge clk);
    we = w; is_word = iw; addr = a; wdata = d;
    if (sel) req_b = 1'b1; else req_a = 1'b1;
    @(negedge clk);
    req_a = 1'b0; req_b = 1'b0;
    lat = -1; rd = '0; busy_bad = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      b = sel ? busy_b : busy_a;
      if (lat >= 0) begin
        if (b !== 1'b0) busy_bad = 1'b1;
        break;
      end
      if (b !== 1'b1) busy_bad = 1'b1;
      if ((sel ? ack_b : ack_a) === 1'b1) begin
        lat = k;
        rd  = sel ? rdata_b : rdata_a;
      end
      @(negedge clk);
    end
    if (!sel && w) ref_a[a[11:2]] = exp_write(ref_a[a[11:2]], iw, int'(a[1:0]), d);
    if (sel && w) ref_b[a[11:2]] = exp_write(ref_b[a[11:2]], iw, int'(a[1:0]), d);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    vectors += 4;
    if (busy_a !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy_a); end
    if (ack_a !== 1'b0) begin errors++; $display("FAIL reset_ack: got %b want 0", ack_a); end
    if (rdata_a !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h want 0", rdata_a); end
    if (perr_a !== 1'b0) begin errors++; $display("FAIL reset_perr: got %b want 0", perr_a); end
  endtask

  task automatic test_word_timing();
    int lat; logic [31:0] rd; bit bb;
    access(0, 1'b1, 1'b1, 12'h010, 32'hDEADBEEF, lat, rd, bb);
    vectors++;
    if (lat !== LatA || bb) begin
      errors++; $display("FAIL word_write_timing: got lat %0d busy_bad %0d want lat %0d", lat, bb, LatA);
    end
    access(0, 1'b0, 1'b1, 12'h010, 32'h0, lat, rd, bb);
    vectors += 2;
    if (lat !== LatA || bb) begin
      errors++; $display("FAIL word_read_timing: got lat %0d busy_bad %0d want lat %0d", lat, bb, LatA);
    end
    if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL word_read: got %h want deadbeef", rd); end
    access(0, 1'b1, 1'b1, 12'h014, 32'h01020304, lat, rd, bb);
    vectors++;
    if (rd !== 32'hDEADBEEF) begin
      errors++; $display("FAIL write_ack_rdata_hold: got %h want deadbeef", rd);
    end
  endtask

  task automatic test_byte();
    int lat; logic [31:0] rd; bit bb;
    access(0, 1'b1, 1'b1, 12'h010, 32'h11223344, lat, rd, bb);
    access(0, 1'b1, 1'b0, 12'h013, 32'h555555AA, lat, rd, bb);
    access(0, 1'b0, 1'b1, 12'h010, 32'h0, lat, rd, bb);
    vectors++;
    if (rd !== 32'hAA223344) begin errors++; $display("FAIL byte_merge: got %h want aa223344", rd); end
    access(0, 1'b0, 1'b0, 12'h012, 32'h0, lat, rd, bb);
    vectors++;
    if (rd !== 32'h00000022) begin errors++; $display("FAIL byte_read: got %h want 00000022", rd); end
  endtask

  task automatic test_random();
    int lat; logic [31:0] rd, last, d, want; bit bb;
    logic w, iw; logic [11:0] a;
    for (int i = 0; i < 16; i++) begin
      access(0, 1'b1, 1'b1, 12'h100 + 12'(4 * i), $urandom, lat, rd, bb);
    end
    access(0, 1'b0, 1'b1, 12'h100, 32'h0, lat, last, bb);
    for (int i = 0; i < 40; i++) begin
      w  = 1'($urandom_range(0, 1));
      iw = 1'($urandom_range(0, 1));
      a  = 12'h100 + 12'(4 * $urandom_range(0, 15)) + (iw ? 12'd0 : 12'($urandom_range(0, 3)));
      d  = $urandom;
      want = w ? last : exp_read(ref_a[a[11:2]], iw, int'(a[1:0]));
      access(0, w, iw, a, d, lat, rd, bb);
      vectors += 2;
      if (lat !== LatA || bb) begin
        errors++; $display("FAIL rand_timing[%0d]: got lat %0d busy_bad %0d want %0d", i, lat, bb, LatA);
      end
      if (rd !== want) begin
        errors++;
        $display("FAIL rand_rdata[%0d] we=%b word=%b addr=%h: got %h want %h", i, w, iw, a, rd, want);
      end
      if (!w) last = want;
    end
  endtask

  task automatic test_drop();
    int lat, acks, ack_k; logic [31:0] rd, first_rd; bit bb;
    access(0, 1'b1, 1'b1, 12'h040, 32'hCAFEF00D, lat, rd, bb);
    @(negedge clk);
    we = 1'b0; is_word = 1'b1; addr = 12'h010; req_a = 1'b1;
    @(negedge clk);
    req_a = 1'b0;
    @(negedge clk);
    acks = 0; ack_k = -1; first_rd = '0;
    for (int k = 2; k <= 14; k++) begin
      if (ack_a === 1'b1) begin
        acks++;
        if (ack_k < 0) begin ack_k = k; first_rd = rdata_a; end
      end
      if (k == 2) begin
        req_a = 1'b1; we = 1'b1; addr = 12'h040; wdata = 32'h12345678;
      end else begin
        req_a = 1'b0;
      end
      @(negedge clk);
    end
    vectors += 4;
    if (acks !== 1 || ack_k !== LatA) begin
      errors++; $display("FAIL drop_acks: got %0d acks first at %0d want 1 at %0d", acks, ack_k, LatA);
    end
    if (first_rd !== ref_a[4]) begin
      errors++; $display("FAIL drop_rdata: got %h want %h", first_rd, ref_a[4]);
    end
    if (perr_a !== PcEn) begin errors++; $display("FAIL drop_perr: got %b want %b", perr_a, PcEn); end
    access(0, 1'b0, 1'b1, 12'h040, 32'h0, lat, rd, bb);
    if (rd !== 32'hCAFEF00D) begin errors++; $display("FAIL drop_no_write: got %h want cafef00d", rd); end
  endtask

  task automatic test_reset_mid();
    int lat; logic [31:0] rd; bit bb;
    access(0, 1'b1, 1'b1, 12'h020, 32'h0, lat, rd, bb);
    @(negedge clk);
    we = 1'b1; is_word = 1'b1; addr = 12'h020; wdata = 32'h5; req_a = 1'b1;
    @(negedge clk);
    req_a = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    vectors += 3;
    if (busy_a !== 1'b0) begin errors++; $display("FAIL mid_reset_busy: got %b want 0", busy_a); end
    if (ack_a !== 1'b0) begin errors++; $display("FAIL mid_reset_ack: got %b want 0", ack_a); end
    if (perr_a !== 1'b0) begin errors++; $display("FAIL mid_reset_perr: got %b want 0", perr_a); end
    @(negedge clk);
    rst_n = 1'b1;
    access(0, 1'b0, 1'b1, 12'h020, 32'h0, lat, rd, bb);
    vectors++;
    if (rd !== 32'h0) begin errors++; $display("FAIL mid_reset_lost_write: got %h want 0", rd); end
  endtask

  task automatic test_misaligned();
    int lat; logic [31:0] rd; bit bb;
    access(0, 1'b0, 1'b1, 12'h011, 32'h0, lat, rd, bb);
    vectors += 2;
    if (rd !== ref_a[4]) begin errors++; $display("FAIL misaligned_rdata: got %h want %h", rd, ref_a[4]); end
    if (perr_a !== PcEn) begin errors++; $display("FAIL misaligned_perr: got %b want %b", perr_a, PcEn); end
    repeat (3) @(negedge clk);
    vectors++;
    if (perr_a !== PcEn) begin errors++; $display("FAIL perr_sticky: got %b want %b", perr_a, PcEn); end
    apply_reset();
    vectors++;
    if (perr_a !== 1'b0) begin errors++; $display("FAIL perr_cleared: got %b want 0", perr_a); end
  endtask

  task automatic test_latency1();
    int lat; logic [31:0] rd, want; bit bb; logic exp_ack;
    for (int i = 0; i < 3; i++) begin
      access(1, 1'b1, 1'b1, 12'(4 * i), $urandom, lat, rd, bb);
      vectors++;
      if (lat !== LatB || bb) begin
        errors++; $display("FAIL lat1_write_timing[%0d]: got lat %0d busy_bad %0d want 1", i, lat, bb);
      end
    end
    @(negedge clk);
    we = 1'b0; is_word = 1'b1; addr = 12'h000; req_b = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (c == 6) req_b = 1'b0;
      exp_ack = (c % 2 == 1);
      vectors++;
      if (ack_b !== exp_ack) begin
        errors++; $display("FAIL lat1_ack_cycle%0d: got %b want %b", c, ack_b, exp_ack);
      end
      if (exp_ack) begin
        want = ref_b[(c - 1) / 2];
        vectors++;
        if (rdata_b !== want) begin
          errors++; $display("FAIL lat1_rdata_cycle%0d: got %h want %h", c, rdata_b, want);
        end
        addr = 12'(((c + 1) / 2) * 4);
      end
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    vectors = 0;
    errors  = 0;
    rst_n   = 1'b0;
    req_a   = 1'b0;
    req_b   = 1'b0;
    we      = 1'b0;
    is_word = 1'b0;
    addr    = '0;
    wdata   = '0;
    test_reset();
    test_word_timing();
    test_byte();
    test_random();
    test_drop();
    test_reset_mid();
    test_misaligned();
    test_latency1();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
